// File: rtl/basys3_display_pkg.sv
// rtl/basys3_display_pkg.sv - shared types and constants for the Basys3 display controller
package basys3_display_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_COMMIT
  } state_t;

  localparam int          BIN_W             = 14;
  localparam int          BCD_W             = 16;
  localparam int          DIGITS            = 4;
  localparam logic [13:0] MAX_DISPLAY_VALUE = 14'd9999;
  localparam logic [3:0]  ERR_DIGIT         = 4'hE;

  // Enable every digit at or below the most significant nonzero one; digit0 always lit.
  function automatic logic [DIGITS-1:0] lz_enables(input logic [BCD_W-1:0] bcd, input logic blank);
    logic [DIGITS-1:0] en;
    en[3] = !blank || (bcd[15:12] != 4'd0);
    en[2] = en[3]  || (bcd[11:8]  != 4'd0);
    en[1] = en[2]  || (bcd[7:4]   != 4'd0);
    en[0] = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/basys3_display_ctrl_bin2bcd_serial.sv
// rtl/basys3_display_ctrl_bin2bcd_serial.sv - serial shift-add-3 binary to BCD converter
// One input bit per cycle after start; done_o marks the cycle performing the final shift.
module bin2bcd_serial
  import basys3_display_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [3:0]       r_cnt;
  logic             r_busy;
  logic [BCD_W-1:0] w_next;

  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd, input logic in_bit);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], in_bit};
  endfunction

  assign w_next = dabble_step(r_bcd, r_bin[BIN_W-1]);
  assign done_o = r_busy && (r_cnt == 4'(BIN_W - 1));
  assign bcd_o  = r_bcd;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start_i) begin
      r_bin  <= bin_i;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bcd <= w_next;
      r_bin <= {r_bin[BIN_W-2:0], 1'b0};
      r_cnt <= r_cnt + 4'd1;
      if (done_o) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/basys3_display_ctrl.sv
// rtl/basys3_display_ctrl.sv - 4-digit BCD display controller with leading-zero blanking
// Blinking is compiled in only when BASYS3_DISPLAY_CTRL_BLINK_EN is defined.
module basys3_display_ctrl
  import basys3_display_pkg::*;
#(
  parameter int BLINK_HALF_MS = 250,
  parameter int LZ_BLANK      = 1
) (
  input  logic        clk_1k_i,
  input  logic        rst_ni,
  input  logic        value_valid_i,
  input  logic [13:0] value_i,
  output logic        value_ready_o,
  input  logic        blink_i,
  output logic        digit0_en_o,
  output logic        digit1_en_o,
  output logic        digit2_en_o,
  output logic        digit3_en_o,
  output logic [3:0]  digit0_o,
  output logic [3:0]  digit1_o,
  output logic [3:0]  digit2_o,
  output logic [3:0]  digit3_o
);

  localparam logic             LZ_ON    = (LZ_BLANK != 0);
  localparam logic [DIGITS-1:0] EN_RESET = {{3{!LZ_ON}}, 1'b1};

  state_t            r_state;
  logic              r_ready;
  logic              r_ovf;
  logic [BCD_W-1:0]  r_digits;
  logic [DIGITS-1:0] r_en;
  logic [DIGITS-1:0] w_en_out;
  logic              w_accept;
  logic              w_done;
  logic [BCD_W-1:0]  w_bcd;

  assign w_accept = value_valid_i && r_ready;

  bin2bcd_serial u_bin2bcd (
    .clk_i  (clk_1k_i),
    .rst_ni (rst_ni),
    .start_i(w_accept),
    .bin_i  (value_i),
    .done_o (w_done),
    .bcd_o  (w_bcd)
  );

  always_ff @(posedge clk_1k_i) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_ovf    <= 1'b0;
      r_digits <= '0;
      r_en     <= EN_RESET;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_state <= S_CONVERT;
          r_ready <= 1'b0;
          r_ovf   <= (value_i > MAX_DISPLAY_VALUE);
        end
        S_CONVERT: if (w_done) r_state <= S_COMMIT;
        S_COMMIT: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          if (r_ovf) begin
            r_digits <= {DIGITS{ERR_DIGIT}};
            r_en     <= '1;
          end else begin
            r_digits <= w_bcd;
            r_en     <= lz_enables(w_bcd, LZ_ON);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef BASYS3_DISPLAY_CTRL_BLINK_EN
  logic [9:0] r_blink_cnt;
  logic       r_phase_on;

  always_ff @(posedge clk_1k_i) begin
    if (!rst_ni || !blink_i) begin
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
    end else if (r_blink_cnt == 10'(BLINK_HALF_MS - 1)) begin
      r_blink_cnt <= '0;
      r_phase_on  <= !r_phase_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + 10'd1;
    end
  end

  assign w_en_out = r_en & {DIGITS{r_phase_on}};
`else
  logic       w_unused_blink;
  logic [9:0] w_unused_half;
  assign w_unused_blink = blink_i;
  assign w_unused_half  = 10'(BLINK_HALF_MS);
  assign w_en_out       = r_en;
`endif

  assign value_ready_o = r_ready;
  assign digit0_o      = r_digits[3:0];
  assign digit1_o      = r_digits[7:4];
  assign digit2_o      = r_digits[11:8];
  assign digit3_o      = r_digits[15:12];
  assign digit0_en_o   = w_en_out[0];
  assign digit1_en_o   = w_en_out[1];
  assign digit2_en_o   = w_en_out[2];
  assign digit3_en_o   = w_en_out[3];

endmodule

// File: tb/tb_basys3_display_ctrl.sv
// tb/tb_basys3_display_ctrl.sv - directed self-checking bench, LZ_BLANK=1 and LZ_BLANK=0 side by side
module tb_basys3_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [13:0] value;
  logic        blink;

  logic        a_ready, a_en0, a_en1, a_en2, a_en3;
  logic [3:0]  a_d0, a_d1, a_d2, a_d3;
  logic        b_ready, b_en0, b_en1, b_en2, b_en3;
  logic [3:0]  b_d0, b_d1, b_d2, b_d3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  basys3_display_ctrl #(.BLINK_HALF_MS(4), .LZ_BLANK(1)) dut_a (
    .clk_1k_i(clk), .rst_ni(rst_n), .value_valid_i(valid), .value_i(value),
    .value_ready_o(a_ready), .blink_i(blink),
    .digit0_en_o(a_en0), .digit1_en_o(a_en1), .digit2_en_o(a_en2), .digit3_en_o(a_en3),
    .digit0_o(a_d0), .digit1_o(a_d1), .digit2_o(a_d2), .digit3_o(a_d3)
  );

  basys3_display_ctrl #(.BLINK_HALF_MS(4), .LZ_BLANK(0)) dut_b (
    .clk_1k_i(clk), .rst_ni(rst_n), .value_valid_i(valid), .value_i(value),
    .value_ready_o(b_ready), .blink_i(blink),
    .digit0_en_o(b_en0), .digit1_en_o(b_en1), .digit2_en_o(b_en2), .digit3_en_o(b_en3),
    .digit0_o(b_d0), .digit1_o(b_d1), .digit2_o(b_d2), .digit3_o(b_d3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Both instances hold the same digits; enables and ready checked per instance.
  task automatic check_disp(input string tag, input logic [15:0] dig,
                            input logic [3:0] en_a, input logic [3:0] en_b, input logic rdy);
    check({tag, "_a_dig"}, {16'h0, a_d3, a_d2, a_d1, a_d0}, {16'h0, dig});
    check({tag, "_b_dig"}, {16'h0, b_d3, b_d2, b_d1, b_d0}, {16'h0, dig});
    check({tag, "_a_en"},  {28'h0, a_en3, a_en2, a_en1, a_en0}, {28'h0, en_a});
    check({tag, "_b_en"},  {28'h0, b_en3, b_en2, b_en1, b_en0}, {28'h0, en_b});
    check({tag, "_rdy"},   {30'h0, a_ready, b_ready}, {30'h0, rdy, rdy});
  endtask

  // Accept v on the next edge (cycle 0), then walk to cycle 16; old digits must hold until then.
  task automatic send(input string tag, input logic [13:0] v, input logic [15:0] old_dig,
                      input logic [3:0] old_a, input logic [3:0] old_b,
                      input logic [15:0] dig, input logic [3:0] en_a, input logic [3:0] en_b);
    valid = 1'b1;
    value = v;
    tick();
    valid = 1'b0;
    check({tag, "_c1_rdy"}, {31'h0, a_ready}, 32'h0);
    for (int i = 2; i <= 15; i++) tick();
    check_disp({tag, "_c15"}, old_dig, old_a, old_b, 1'b0);
    tick();
    check_disp({tag, "_c16"}, dig, en_a, en_b, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    value = '0;
    blink = 1'b0;
    tick();
    tick();
    check_disp("reset", 16'h0000, 4'b0001, 4'b1111, 1'b1);
    rst_n = 1'b1;
    tick();
    check_disp("idle", 16'h0000, 4'b0001, 4'b1111, 1'b1);

    send("v1234", 14'd1234, 16'h0000, 4'b0001, 4'b1111, 16'h1234, 4'b1111, 4'b1111);
    send("v7",    14'd7,    16'h1234, 4'b1111, 4'b1111, 16'h0007, 4'b0001, 4'b1111);
    send("v12000", 14'd12000, 16'h0007, 4'b0001, 4'b1111, 16'hEEEE, 4'b1111, 4'b1111);
    send("v9999", 14'd9999, 16'hEEEE, 4'b1111, 4'b1111, 16'h9999, 4'b1111, 4'b1111);
    send("v10000", 14'd10000, 16'h9999, 4'b1111, 4'b1111, 16'hEEEE, 4'b1111, 4'b1111);
    send("v0",    14'd0,    16'hEEEE, 4'b1111, 4'b1111, 16'h0000, 4'b0001, 4'b1111);
    send("v16383", 14'd16383, 16'h0000, 4'b0001, 4'b1111, 16'hEEEE, 4'b1111, 4'b1111);
    send("v100",  14'd100,  16'hEEEE, 4'b1111, 4'b1111, 16'h0100, 4'b0111, 4'b1111);

    // Held valid: value_i changes mid-conversion are ignored, next value taken in IDLE.
    valid = 1'b1;
    value = 14'd2024;
    tick();
    tick();
    tick();
    value = 14'd55;
    for (int i = 4; i <= 16; i++) tick();
    check_disp("held_c16", 16'h2024, 4'b1111, 4'b1111, 1'b1);
    tick();
    valid = 1'b0;
    check("held_c17_rdy", {31'h0, a_ready}, 32'h0);
    for (int i = 18; i <= 32; i++) tick();
    check_disp("held_2nd", 16'h0055, 4'b0011, 4'b1111, 1'b1);

    send("v42", 14'd42, 16'h0055, 4'b0011, 4'b1111, 16'h0042, 4'b0011, 4'b1111);

    // Reset during CONVERT at cycle 5: 5678 must never reach the display.
    valid = 1'b1;
    value = 14'd5678;
    tick();
    valid = 1'b0;
    for (int i = 2; i <= 5; i++) tick();
    check_disp("abort_c5", 16'h0042, 4'b0011, 4'b1111, 1'b0);
    rst_n = 1'b0;
    tick();
    check_disp("abort_rst", 16'h0000, 4'b0001, 4'b1111, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check_disp("abort_after", 16'h0000, 4'b0001, 4'b1111, 1'b1);

    send("v8421", 14'd8421, 16'h0000, 4'b0001, 4'b1111, 16'h8421, 4'b1111, 4'b1111);

    blink = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
`ifdef BASYS3_DISPLAY_CTRL_BLINK_EN
      check($sformatf("blink_%0d", i), {28'h0, a_en3, a_en2, a_en1, a_en0},
            (((i / 4) % 2) == 0) ? 32'hF : 32'h0);
`else
      check($sformatf("noblink_%0d", i), {28'h0, a_en3, a_en2, a_en1, a_en0}, 32'hF);
`endif
    end
    blink = 1'b0;
    tick();
    check_disp("blink_off", 16'h8421, 4'b1111, 4'b1111, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/basys3_display_ctrl.md
BASYS3_DISPLAY_CTRL -- requirements
Module: basys3_display_ctrl

Interface
REQ-001 SHALL have parameter BLINK_HALF_MS, default 250: blink half-period in clk_1k_i cycles, legal range 2..1023.
REQ-002 SHALL have parameter LZ_BLANK, default 1: 1 = blank leading zeros, 0 = show all four digits.
REQ-003 SHALL have port clk_1k_i, input, 1 bit: single clock (1 kHz display clock).
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port value_valid_i, input, 1 bit: new binary value offered.
REQ-006 SHALL have port value_i, input, 14 bits: unsigned binary value to display.
REQ-007 SHALL have port value_ready_o, output, 1 bit: block can accept a value.
REQ-008 SHALL have port blink_i, input, 1 bit: level-sensitive blink request.
REQ-009 SHALL have ports digitN_en_o (N=0..3), output, 1 bit each: per-digit enable for the 7-seg driver; digit0 = least significant.
REQ-010 SHALL have ports digitN_o (N=0..3), output, 4 bits each: per-digit code for the 7-seg driver.

Function
REQ-011 SHALL implement FSM states IDLE, CONVERT, COMMIT; value_ready_o = 1 only in IDLE.
REQ-012 SHALL accept a value when value_valid_i && value_ready_o; IDLE -> CONVERT on acceptance, value_i captured that cycle.
REQ-013 SHALL convert binary to BCD serially by shift-add-3, one bit per cycle, 14 cycles in CONVERT, then COMMIT for 1 cycle, then IDLE.
REQ-014 SHALL update digit outputs in the cycle after COMMIT: fixed 16-cycle latency from acceptance edge to new outputs; value_ready_o high again in that same cycle.
REQ-015 SHALL hold the previously displayed digits unchanged during CONVERT/COMMIT (no partial values visible).
REQ-016 SHALL, for captured value > 9999, run the same 16-cycle sequence and commit 4'hE on all four digits with all enables 1 (overflow display "EEEE").
REQ-017 SHALL, with LZ_BLANK=1, disable every digit above the most significant nonzero digit; digit0 is always enabled (value 0 shows "0").
REQ-018 SHALL, with LZ_BLANK=0, enable all four digits for in-range values.
REQ-019 SHALL ignore value_valid_i outside IDLE; a held valid is accepted on the first IDLE cycle.
REQ-020 SHALL, while blink_i = 1, count 0..BLINK_HALF_MS-1 and toggle an on/off phase at each wrap; the off phase forces all four enables to 0; digit codes are unaffected.
REQ-021 SHALL, while blink_i = 0, hold the blink counter at 0 and the phase at on; on blink_i rising, the first off phase begins BLINK_HALF_MS cycles later.
REQ-022 SHALL apply blink masking combinationally over committed enables; a commit during the off phase stays hidden until the on phase.

Reset
REQ-023 SHALL, on rst_ni = 0 at a clock edge, enter IDLE, clear BCD shift state, blink counter = 0, phase = on.
REQ-024 SHALL reset outputs to: all digitN_o = 0; digit0_en_o = 1; digit1..3_en_o = LZ_BLANK ? 0 : 1; value_ready_o = 1 in the first cycle after reset.
REQ-025 SHALL abort any conversion in progress when reset occurs mid-CONVERT; the aborted value is never committed.

Configuration
REQ-026 SHALL compile blinking only when macro BASYS3_DISPLAY_CTRL_BLINK_EN is defined.
REQ-027 SHALL, without BASYS3_DISPLAY_CTRL_BLINK_EN, keep blink_i as a port, ignore it, instantiate no blink counter, and pass committed enables through unmasked.

Structure
REQ-028 SHALL place the FSM state enum, MAX_DISPLAY_VALUE = 9999, ERR_DIGIT = 4'hE and BCD width constants in package basys3_display_pkg.
REQ-029 SHALL implement the serial shift-add-3 datapath in sub-module bin2bcd_serial (start, 14-bit in, done, 16-bit BCD out), sequenced by the parent FSM.

Verification
REQ-030 SHALL cover: after reset with no stimulus, outputs match REQ-024 and value_ready_o = 1.
REQ-031 SHALL cover: accept 1234 at cycle 0 -> ready low cycles 1..15; at cycle 16 digits 3,2,1,0 = 1,2,3,4, all enabled, ready = 1.
REQ-032 SHALL cover: accept 7 with LZ_BLANK=1 -> digit0 = 7, en = 0001; same with LZ_BLANK=0 -> 0007, en = 1111.
REQ-033 SHALL cover: accept 12000 -> after 16 cycles all digits = 4'hE, en = 1111; accept 9999 -> 9999.
REQ-034 SHALL cover: display 42, then accept 5678; assert rst_ni low at cycle 5 -> reset outputs; 5678 never appears.
REQ-035 SHALL cover: BASYS3_DISPLAY_CTRL_BLINK_EN defined, BLINK_HALF_MS=4, blink_i=1 -> enables on 4 cycles, off 4, repeating; blink_i=0 -> enables restored next cycle; macro undefined -> no masking.
